// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative multiply/divide sequencer.
// Opcodes, FSM states and the divide-by-zero result.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_UDIV  = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Replicated across the result width; ARMv8 defines x/0 as zero.
  localparam bit DIV0_RESULT = 1'b0;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between decode/EX and the
// multiply/divide sequencer.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 64
) ();

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             stall;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result, stall
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result, stall
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration
// over the {hi,lo} working pair, sharing a single adder width.
module muldiv_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  input  logic             is_div,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    shl  = {hi, lo[WIDTH-1]};
    // remainder stays below b, so the low bits of the difference suffice
    diff = shl[WIDTH-1:0] - b;
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      if (shl >= {1'b0, b}) begin
        hi_nxt = diff;
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shl[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: WIDTH-cycle MUL/UMULH/UDIV sequencer for the EX stage;
// stalls the front of the pipe until the result is ready.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, bq, res;
  logic [WIDTH-1:0] hi_n, lo_n;
  op_t              opq;
  logic             accept, div0, last;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .hi     (hi),
    .lo     (lo),
    .b      (bq),
    .is_div (opq == OP_UDIV),
    .hi_nxt (hi_n),
    .lo_nxt (lo_n)
  );

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    div0    = 1'b0;
    last    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start && !bus.flush && bus.op != OP_RSVD) begin
          accept  = 1'b1;
          div0    = (bus.op == OP_UDIV) && (bus.b == '0);
          state_n = div0 ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_n = S_IDLE;
        end else if (cnt == LAST) begin
          last    = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      bq    <= '0;
      opq   <= OP_MUL;
      res   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        hi  <= '0;
        lo  <= bus.a;
        bq  <= bus.b;
        opq <= bus.op;
        cnt <= '0;
        if (div0) res <= {WIDTH{DIV0_RESULT}};
      end else if (state == S_RUN && !bus.flush) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + 1'b1;
        if (last) res <= (opq == OP_UMULH) ? hi_n : lo_n;
      end
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE) && !bus.flush;
  assign bus.result = res;
  assign bus.stall  = bus.busy |
                      (bus.start && state == S_IDLE &&
                       bus.op != OP_RSVD);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus hand-written flush,
// busy-start, mid-run reset and reserved-op sequences.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  typedef struct {
    op_t         op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  muldiv_if #(.WIDTH(64)) bus ();

  muldiv_seq #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // launch at a negedge; returns at the negedge following the start edge
  task automatic issue(input op_t o, input logic [63:0] x,
                       input logic [63:0] y, input logic exp_stall);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    #1;
    chk("stall_on_start", 64'(bus.stall), 64'(exp_stall));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int drops;
    lat   = 0;
    drops = 0;
    while (!bus.done && lat < 200) begin
      if (!bus.busy) drops++;
      @(negedge clk);
      lat++;
    end
    chk("busy_held", 64'(drops), 64'd0);
    chk("done_seen", 64'(bus.done), 64'd1);
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
  endtask

  vec_t        vecs[9];
  int          lat;
  int          seen;
  logic [63:0] prev;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    vecs[0] = '{OP_MUL,   64'd7, 64'd6, 64'd42, 64};
    vecs[1] = '{OP_UMULH, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 64};
    vecs[2] = '{OP_MUL,   64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
                64'hFFFF_FFFF_FFFF_FFF1, 64};
    vecs[3] = '{OP_UDIV,  64'd100, 64'd7, 64'd14, 64};
    vecs[4] = '{OP_UDIV,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                64'hFFFF_FFFF_FFFF_FFFF, 64};
    vecs[5] = '{OP_UDIV,  64'd55, 64'd0, 64'd0, 0};
    vecs[6] = '{OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64};
    vecs[7] = '{OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64};
    vecs[8] = '{OP_UDIV,  64'hFFFF_FFFF_FFFF_FFFF,
                64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 64};

    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(bus.busy),  64'd0);
    chk("rst_done",   64'(bus.done),  64'd0);
    chk("rst_result", bus.result,     64'd0);
    chk("rst_stall",  64'(bus.stall), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_res", i), bus.result, vecs[i].exp);
      @(negedge clk);
      chk($sformatf("v%0d_done_off", i), 64'(bus.done), 64'd0);
      chk($sformatf("v%0d_idle", i), 64'(bus.busy), 64'd0);
      chk($sformatf("v%0d_hold", i), bus.result, vecs[i].exp);
    end

    // flush at iteration 10
    prev = bus.result;
    issue(OP_MUL, 64'd5, 64'd5, 1'b1);
    count_done(10, seen);
    bus.flush = 1'b1;
    #1;
    chk("flush_done_low", 64'(bus.done), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_result", bus.result, prev);
    chk("flush_no_done", 64'(seen), 64'd0);
    issue(OP_MUL, 64'd3, 64'd3, 1'b1);
    wait_done(lat);
    chk("after_flush_lat", 64'(lat), 64'd64);
    chk("after_flush_res", bus.result, 64'd9);

    // start while busy at iteration 20 is ignored
    issue(OP_MUL, 64'd11, 64'd13, 1'b1);
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_UDIV;
    bus.a     = 64'd1;
    bus.b     = 64'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    chk("busy_start_lat", 64'(lat + 21), 64'd64);
    chk("busy_start_res", bus.result, 64'd143);
    @(negedge clk);

    // reset at iteration 30
    issue(OP_MUL, 64'd9, 64'd9, 1'b1);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy",   64'(bus.busy),  64'd0);
    chk("mid_rst_done",   64'(bus.done),  64'd0);
    chk("mid_rst_result", bus.result,     64'd0);
    chk("mid_rst_stall",  64'(bus.stall), 64'd0);
    count_done(70, seen);
    chk("mid_rst_no_done", 64'(seen), 64'd0);

    // reserved opcode does nothing
    issue(OP_RSVD, 64'd4, 64'd4, 1'b0);
    chk("rsvd_busy", 64'(bus.busy), 64'd0);
    count_done(70, seen);
    chk("rsvd_no_done", 64'(seen), 64'd0);
    chk("rsvd_result", bus.result, 64'd0);

    // flush in IDLE blocks a simultaneous start
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 64'd2;
    bus.b     = 64'd2;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush_busy", 64'(bus.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer for the pipelined LEGv8 core's EX stage. Executes MUL, UMULH and UDIV over WIDTH cycles using one shared adder/subtractor, so no extra combinational multiplier or divider is needed. Holds the pipeline via a stall output until the result is ready for EX/MEM. Driven by main decode once an R-type multiply/divide funct is recognised.

Parameters:
WIDTH, 64, operand/result width in bits; must be >= 4.
CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request a new operation; sampled only in IDLE.
op  in  2  00 MUL (low WIDTH bits), 01 UMULH (high WIDTH bits, unsigned), 10 UDIV (unsigned quotient), 11 reserved.
a  in  WIDTH  operand Rn; captured when start is accepted.
b  in  WIDTH  operand Rm; captured when start is accepted.
flush  in  1  abort the in-flight operation (branch mispredict/exception).
busy  out  1  high in RUN and DONE states.
done  out  1  one-cycle pulse; result valid in the same cycle.
result  out  WIDTH  registered result; holds its value until the next done.
stall  out  1  combinational: busy | (start & state==IDLE & op!=11); freezes IF/ID/EX.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0. Takes priority over all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start & op!=11 & !(op==10 & b==0): capture a, b and op; counter=0; go to RUN.
  - UDIV with b==0: go directly to DONE with result=0 (ARMv8 semantics); latency 1 edge.
  - op==11: ignored; stays IDLE, stall=0.
- RUN: one iteration per cycle; counter increments each cycle. After the iteration with counter==WIDTH-1, go to DONE.
- Multiply (shift-add, unsigned):
  - 2*WIDTH product register {hi,lo}; lo initialised to a, hi to 0.
  - Each cycle: if lo[0], hi += b with carry kept (WIDTH+1-bit add); then shift {carry,hi,lo} right 1.
  - MUL takes lo; UMULH takes hi. MUL low bits are identical for signed operands.
- Divide (restoring, unsigned):
  - Remainder R (WIDTH+1 bits) = 0; quotient Q = a.
  - Each cycle: {R,Q} <<= 1; T = R - b. If T >= 0 then R = T and Q[0] = 1, else Q[0] = 0.
  - Result is Q.
- DONE: done=1 for exactly one cycle; result register loaded on the entry edge. Unconditionally returns to IDLE.
- Latency: start accepted at edge E0; done high in the cycle after edge E(WIDTH). A new start is accepted at edge E(WIDTH+1), i.e. the cycle after done.
- start while busy: ignored; captured operands are unaffected.
- flush:
  - In RUN or DONE: next state IDLE, done forced 0, result unchanged.
  - In IDLE: blocks acceptance of a simultaneous start.
- reset asserted mid-operation: behaves as reset; no done pulse.
- All arithmetic is modulo 2^WIDTH unless stated otherwise; no overflow flags are produced.

Decomposition:
- Package muldiv_pkg:
  - typedef enum logic [1:0] op_t {OP_MUL, OP_UMULH, OP_UDIV, OP_RSVD}.
  - typedef enum logic [1:0] state_t {S_IDLE, S_RUN, S_DONE}.
  - localparam DIV0_RESULT = '0.
- One sub-module, muldiv_step: combinational single iteration. Inputs hi, lo, b, is_div; outputs next hi and lo. Keeps the FSM file to control and registers only.

Test Plan:
- MUL: a=7, b=6, pulse start -> stall=1 that cycle; busy for 65 cycles; done exactly one cycle after edge E64 with result=42; busy=0 the next cycle.
- UMULH: a=64'h8000_0000_0000_0000, b=4 -> result=2. MUL with a=-3 (two's complement), b=5 -> result=-15.
- UDIV: a=100, b=7 -> result=14. UDIV a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> result=all ones.
- UDIV by zero: a=55, b=0 -> done in the cycle after the start edge, result=0, no RUN cycles.
- flush asserted at iteration 10 -> busy=0 next cycle, no done, result keeps its previous value. Immediate new MUL 3*3 -> 9 with normal latency.
- start pulsed with different operands at iteration 20 -> ignored; original result delivered. reset at iteration 30 -> all outputs 0 next cycle, no done. op=11 -> stall=0, no state change.
